// File: rtl/fpu_bus_if.sv
// Host-bus front end for the FPU core: synchronised chip-select register file,
// operand/command/status/result map and start/done handshake to the arithmetic core.
module fpu_bus_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned OPERAND_W = 32,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned OPCODE_W  = 4,
  parameter int unsigned FLAG_W    = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [DATA_W-1:0]    databus_in,
  output logic [DATA_W-1:0]    databus_out,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 cs,
  input  logic                 rd,
  input  logic                 wr,
  input  logic                 end_ack,
  output logic                 cmd_end,
  output logic                 busy,
  output logic                 core_start,
  output logic [OPCODE_W-1:0]  core_op,
  output logic [OPERAND_W-1:0] core_a,
  output logic [OPERAND_W-1:0] core_b,
  input  logic                 core_done,
  input  logic [OPERAND_W-1:0] core_result,
  input  logic [FLAG_W-1:0]    core_flags
);

  localparam int unsigned NB          = OPERAND_W / DATA_W;
  localparam int unsigned B_BASE      = NB;
  localparam int unsigned CMD_ADDR    = 2 * NB;
  localparam int unsigned STATUS_ADDR = 2 * NB + 1;
  localparam int unsigned RES_BASE    = 2 * NB + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                state_q;
  logic [2:0]            sync1_q, sync2_q;
  logic                  wr_act_c, rd_act_c;
  logic                  wr_act_q, rd_act_q;
  logic                  wr_commit_q, rd_commit_q;
  logic [ADDR_W-1:0]     wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0]     wr_data_q;
  logic [OPERAND_W-1:0]  result_q;
  logic [FLAG_W-1:0]     flags_q;
  logic                  err_q;
  logic                  hit_a_c, hit_b_c, hit_cmd_c;
  logic                  wr_ok_c, busy_wr_c, cmd_wr_c, status_rd_c;
  logic [DATA_W-1:0]     status_c;

  // Strobes are synchronised as active-high flags so a cleared flop means "idle".
  assign wr_act_c = sync2_q[0] & sync2_q[1];
  assign rd_act_c = sync2_q[0] & sync2_q[2];

  // Synchroniser, edge detect and capture of the committed access.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      wr_act_q    <= 1'b0;
      rd_act_q    <= 1'b0;
      wr_commit_q <= 1'b0;
      rd_commit_q <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      sync1_q     <= {~rd, ~wr, ~cs};
      sync2_q     <= sync1_q;
      wr_act_q    <= wr_act_c;
      rd_act_q    <= rd_act_c;
      wr_commit_q <= wr_act_c & ~wr_act_q;
      rd_commit_q <= rd_act_c & ~rd_act_q;
      if (wr_act_c && !wr_act_q) begin
        wr_addr_q <= addr;
        wr_data_q <= databus_in;
      end
      if (rd_act_c && !rd_act_q) begin
        rd_addr_q <= addr;
      end
    end
  end

  assign hit_a_c     = (wr_addr_q < ADDR_W'(NB));
  assign hit_b_c     = (wr_addr_q >= ADDR_W'(B_BASE)) && (wr_addr_q < ADDR_W'(CMD_ADDR));
  assign hit_cmd_c   = (wr_addr_q == ADDR_W'(CMD_ADDR));
  assign wr_ok_c     = wr_commit_q && (state_q != S_RUN);
  assign busy_wr_c   = wr_commit_q && (state_q == S_RUN) && (hit_a_c || hit_b_c || hit_cmd_c);
  assign cmd_wr_c    = wr_ok_c && hit_cmd_c;
  assign status_rd_c = rd_commit_q && (rd_addr_q == ADDR_W'(STATUS_ADDR));

  // Operand lanes, frozen while an operation is in flight.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      core_a <= '0;
      core_b <= '0;
    end else if (wr_ok_c) begin
      for (int k = 0; k < int'(NB); k++) begin
        if (wr_addr_q == ADDR_W'(k))
          core_a[k*DATA_W +: DATA_W] <= wr_data_q;
        if (wr_addr_q == ADDR_W'(B_BASE + k))
          core_b[k*DATA_W +: DATA_W] <= wr_data_q;
      end
    end
  end

  // Sticky error: a busy write in the same cycle as a STATUS read keeps it set.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)            err_q <= 1'b0;
    else if (busy_wr_c)   err_q <= 1'b1;
    else if (status_rd_c) err_q <= 1'b0;
  end

  // Command FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= S_IDLE;
      cmd_end    <= 1'b0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      core_op    <= '0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      core_start <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (cmd_wr_c) begin
            core_op    <= wr_data_q[OPCODE_W-1:0];
            cmd_end    <= 1'b0;
            busy       <= 1'b1;
            core_start <= 1'b1;
            state_q    <= S_RUN;
          end else if (state_q == S_DONE && end_ack) begin
            cmd_end <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (core_done) begin
            result_q <= core_result;
            flags_q  <= core_flags;
            cmd_end  <= 1'b1;
            busy     <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign status_c = DATA_W'({flags_q, err_q, cmd_end, busy});

  // Host read mux, live only while the raw read strobe is asserted.
  always_comb begin
    databus_out = '0;
    if (!cs && !rd) begin
      for (int k = 0; k < int'(NB); k++) begin
        if (addr == ADDR_W'(k))            databus_out = core_a[k*DATA_W +: DATA_W];
        if (addr == ADDR_W'(B_BASE + k))   databus_out = core_b[k*DATA_W +: DATA_W];
        if (addr == ADDR_W'(RES_BASE + k)) databus_out = result_q[k*DATA_W +: DATA_W];
      end
      if (addr == ADDR_W'(STATUS_ADDR)) databus_out = status_c;
    end
  end

endmodule

// File: tb/tb_fpu_bus_if.sv
// Bench for fpu_bus_if: register-map table, directed handshake sequences, randomized
// commands against a register-level model, plus a 16/64-bit instance.
module tb_fpu_bus_if;
  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst;
  logic [15:0]   din;
  logic [AW-1:0] addr;
  logic          rd, wr, cs8, cs16;
  logic [7:0]    dout8;
  logic [15:0]   dout16;
  logic          end_ack8, end_ack16;
  logic          cmd_end8, busy8, core_start8, core_done8;
  logic [3:0]    core_op8, core_flags8;
  logic [31:0]   core_a8, core_b8, core_result8;
  logic          cmd_end16, busy16, core_start16, core_done16;
  logic [3:0]    core_op16, core_flags16;
  logic [63:0]   core_a16, core_b16, core_result16;

  fpu_bus_if u_dut (
    .clk(clk), .arst(arst), .databus_in(din[7:0]), .databus_out(dout8), .addr(addr),
    .cs(cs8), .rd(rd), .wr(wr), .end_ack(end_ack8), .cmd_end(cmd_end8), .busy(busy8),
    .core_start(core_start8), .core_op(core_op8), .core_a(core_a8), .core_b(core_b8),
    .core_done(core_done8), .core_result(core_result8), .core_flags(core_flags8)
  );

  fpu_bus_if #(.DATA_W(16), .OPERAND_W(64)) u_wide (
    .clk(clk), .arst(arst), .databus_in(din), .databus_out(dout16), .addr(addr),
    .cs(cs16), .rd(rd), .wr(wr), .end_ack(end_ack16), .cmd_end(cmd_end16), .busy(busy16),
    .core_start(core_start16), .core_op(core_op16), .core_a(core_a16), .core_b(core_b16),
    .core_done(core_done16), .core_result(core_result16), .core_flags(core_flags16)
  );

  int checks = 0;
  int errors = 0;
  int n_start8 = 0;

  // Reference core behaviour (arbitrary but deterministic arithmetic).
  function automatic logic [31:0] core_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  function automatic logic [3:0] flags_fn(input logic [3:0] op, input logic [31:0] a);
    return op ^ a[3:0];
  endfunction

  function automatic logic [7:0] status_val(input int flags, input int err, input int ce,
                                            input int bsy);
    return 8'(bsy + 2 * ce + 4 * err + 8 * flags);
  endfunction

  // Behavioural core for the narrow instance.
  int          core_lat = 4;
  bit          core_force = 1'b0;
  logic [31:0] force_res = '0;
  initial begin
    logic [3:0]  op_c;
    logic [31:0] a_c, b_c;
    core_done8 = 1'b0; core_result8 = '0; core_flags8 = '0;
    forever begin
      @(posedge clk); #1;
      if (core_start8 === 1'b1) begin
        op_c = core_op8; a_c = core_a8; b_c = core_b8;
        repeat (core_lat) @(posedge clk);
        #1;
        core_result8 = core_force ? force_res : core_fn(op_c, a_c, b_c);
        core_flags8  = core_force ? 4'h0 : flags_fn(op_c, a_c);
        core_done8   = 1'b1;
        @(posedge clk); #1;
        core_done8   = 1'b0;
      end
    end
  end

  always @(posedge clk) if (core_start8 === 1'b1) n_start8 <= n_start8 + 1;

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input bit wide, input int a, input logic [15:0] d, input int hold);
    @(negedge clk);
    addr = AW'(a); din = d; wr = 1'b0;
    if (wide) cs16 = 1'b0; else cs8 = 1'b0;
    repeat (hold) @(negedge clk);
    wr = 1'b1; cs8 = 1'b1; cs16 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_rd(input bit wide, input int a, output logic [15:0] d);
    @(negedge clk);
    addr = AW'(a); rd = 1'b0;
    if (wide) cs16 = 1'b0; else cs8 = 1'b0;
    #1;
    d = wide ? dout16 : {8'h00, dout8};
    repeat (3) @(negedge clk);
    rd = 1'b1; cs8 = 1'b1; cs16 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic rd_check(input bit wide, input string name, input int a,
                          input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(wide, a, d);
    check(name, 64'(d), 64'(exp));
  endtask

  task automatic wait_end8(input string name);
    int n = 0;
    while (cmd_end8 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check(name, 64'(cmd_end8), 64'(1'b1));
  endtask

  task automatic ack8();
    @(negedge clk); end_ack8 = 1'b1;
    @(negedge clk); end_ack8 = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    int          a;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;

  logic [31:0] a_m, b_m, res_m;
  logic [3:0]  flags_m;
  int          err_m, ce_m;

  initial begin
    vec_t        tbl[$];
    logic [15:0] d;
    int          s0;
    logic [3:0]  op;

    tbl.push_back('{1'b1, 0, 8'h11, 8'h00});
    tbl.push_back('{1'b1, 1, 8'h22, 8'h00});
    tbl.push_back('{1'b1, 2, 8'h33, 8'h00});
    tbl.push_back('{1'b1, 3, 8'h44, 8'h00});
    tbl.push_back('{1'b1, 4, 8'h55, 8'h00});
    tbl.push_back('{1'b1, 7, 8'h88, 8'h00});
    tbl.push_back('{1'b1, 9, 8'hFF, 8'h00});
    tbl.push_back('{1'b1, 10, 8'hFF, 8'h00});
    tbl.push_back('{1'b1, 14, 8'hFF, 8'h00});
    tbl.push_back('{1'b0, 0, 8'h00, 8'h11});
    tbl.push_back('{1'b0, 3, 8'h00, 8'h44});
    tbl.push_back('{1'b0, 4, 8'h00, 8'h55});
    tbl.push_back('{1'b0, 5, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 7, 8'h00, 8'h88});
    tbl.push_back('{1'b0, 8, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 9, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 10, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 13, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 14, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 63, 8'h00, 8'h00});

    arst = 1'b0; din = '0; addr = '0; rd = 1'b1; wr = 1'b1; cs8 = 1'b1; cs16 = 1'b1;
    end_ack8 = 1'b0; end_ack16 = 1'b0; core_done16 = 1'b0; core_result16 = '0; core_flags16 = '0;
    repeat (3) @(negedge clk);
    arst = 1'b1;
    @(negedge clk);

    check("rst_busy", 64'(busy8), 64'(1'b0));
    check("rst_cmd_end", 64'(cmd_end8), 64'(1'b0));
    check("rst_core_start", 64'(core_start8), 64'(1'b0));
    check("rst_core_a", 64'(core_a8), 64'h0);
    check("rst_dout_idle", 64'(dout8), 64'h0);

    // Register map edges in IDLE.
    foreach (tbl[i]) begin
      if (tbl[i].is_wr) bus_wr(1'b0, tbl[i].a, {8'h00, tbl[i].d}, 3);
      else rd_check(1'b0, $sformatf("map_rd_%0d", tbl[i].a), tbl[i].a, {8'h00, tbl[i].exp});
    end
    check("map_core_a", 64'(core_a8), 64'h44332211);
    check("map_core_b", 64'(core_b8), 64'h88000055);
    check("map_no_launch", 64'(n_start8), 64'h0);

    // Default launch with a known float product.
    a_m = 32'h401ccccd; b_m = 32'h406a3d71;
    for (int k = 0; k < 4; k++) begin
      bus_wr(1'b0, k, {8'h00, a_m[k*8 +: 8]}, 3);
      bus_wr(1'b0, 4 + k, {8'h00, b_m[k*8 +: 8]}, 3);
    end
    core_force = 1'b1; force_res = 32'h410f78d5; core_lat = 10;
    s0 = n_start8;
    bus_wr(1'b0, 8, 16'h0002, 3);
    check("launch_busy", 64'(busy8), 64'(1'b1));
    check("launch_op", 64'(core_op8), 64'h2);
    wait_end8("launch_done_timeout");
    check("launch_one_start", 64'(n_start8 - s0), 64'd1);
    check("launch_busy_low", 64'(busy8), 64'(1'b0));
    rd_check(1'b0, "res_b0", 10, 16'h00d5);
    rd_check(1'b0, "res_b1", 11, 16'h0078);
    rd_check(1'b0, "res_b2", 12, 16'h000f);
    rd_check(1'b0, "res_b3", 13, 16'h0041);
    rd_check(1'b0, "status_done", 9, 16'h0002);
    ack8();
    check("ack_cmd_end", 64'(cmd_end8), 64'(1'b0));
    rd_check(1'b0, "status_acked", 9, 16'h0000);
    core_force = 1'b0;

    // Write while busy sets a sticky error that a STATUS read clears.
    core_lat = 40;
    bus_wr(1'b0, 8, 16'h0001, 3);
    bus_wr(1'b0, 0, 16'h00FF, 3);
    check("busy_wr_a_frozen", 64'(core_a8), 64'(a_m));
    rd_check(1'b0, "busy_err_set", 9, 16'h0005);
    rd_check(1'b0, "busy_err_clr", 9, 16'h0001);
    wait_end8("busy_done_timeout");
    res_m = core_fn(4'h1, a_m, b_m); flags_m = flags_fn(4'h1, a_m);
    for (int k = 0; k < 4; k++)
      rd_check(1'b0, $sformatf("busy_res_%0d", k), 10 + k, {8'h00, res_m[k*8 +: 8]});

    // Long strobe from DONE launches exactly once; unmapped/read-only accesses are inert.
    core_lat = 3; s0 = n_start8;
    bus_wr(1'b0, 8, 16'h0003, 6);
    wait_end8("long_done_timeout");
    check("long_one_start", 64'(n_start8 - s0), 64'd1);
    res_m = core_fn(4'h3, a_m, b_m); flags_m = flags_fn(4'h3, a_m);
    rd_check(1'b0, "long_rd14", 14, 16'h0000);
    bus_wr(1'b0, 9, 16'h00FF, 3);
    rd_check(1'b0, "long_status", 9, {8'h00, status_val(int'(flags_m), 0, 1, 0)});
    rd_check(1'b0, "long_res0", 10, {8'h00, res_m[7:0]});
    ce_m = 1; err_m = 0;

    // Randomized commands against the register-level model.
    for (int it = 0; it < 20; it++) begin
      bit busy_w;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          d = 16'($urandom_range(0, 255));
          bus_wr(1'b0, k, d, 3);
          if (k < 4) a_m[k*8 +: 8] = d[7:0];
          else b_m[(k-4)*8 +: 8] = d[7:0];
        end
      end
      op = 4'($urandom_range(0, 15));
      busy_w = ($urandom_range(0, 3) == 0);
      core_lat = busy_w ? 40 : $urandom_range(1, 12);
      bus_wr(1'b0, 8, {12'h000, op}, 3);
      if (busy_w) begin
        bus_wr(1'b0, $urandom_range(0, 8), 16'($urandom_range(0, 255)), 3);
        err_m = 1;
      end
      check($sformatf("rnd%0d_a", it), 64'(core_a8), 64'(a_m));
      check($sformatf("rnd%0d_b", it), 64'(core_b8), 64'(b_m));
      check($sformatf("rnd%0d_op", it), 64'(core_op8), 64'(op));
      wait_end8($sformatf("rnd%0d_timeout", it));
      res_m = core_fn(op, a_m, b_m); flags_m = flags_fn(op, a_m);
      for (int k = 0; k < 4; k++)
        rd_check(1'b0, $sformatf("rnd%0d_res%0d", it, k), 10 + k, {8'h00, res_m[k*8 +: 8]});
      rd_check(1'b0, $sformatf("rnd%0d_status", it), 9,
               {8'h00, status_val(int'(flags_m), err_m, 1, 0)});
      err_m = 0;
      if ($urandom_range(0, 1) == 1) begin
        ack8();
        check($sformatf("rnd%0d_ack", it), 64'(cmd_end8), 64'(1'b0));
      end
    end

    // Reset mid-operation; the core's late done must be ignored.
    core_lat = 30;
    bus_wr(1'b0, 8, 16'h0000, 3);
    check("rstrun_busy", 64'(busy8), 64'(1'b1));
    @(negedge clk); arst = 1'b0; #1;
    check("rstrun_async_busy", 64'(busy8), 64'(1'b0));
    repeat (2) @(negedge clk);
    arst = 1'b1;
    repeat (40) @(negedge clk);
    check("rstrun_busy_after", 64'(busy8), 64'(1'b0));
    check("rstrun_cmd_end", 64'(cmd_end8), 64'(1'b0));
    check("rstrun_core_a", 64'(core_a8), 64'h0);
    for (int k = 0; k < 4; k++)
      rd_check(1'b0, $sformatf("rstrun_res%0d", k), 10 + k, 16'h0000);
    rd_check(1'b0, "rstrun_status", 9, 16'h0000);

    // Wide configuration: 16-bit bus, 64-bit operands.
    begin
      logic [63:0] wa, wb, wr_res;
      wa = 64'h4000_0000_0000_0000; wb = 64'h3FF9_21FB_5444_2D18;
      wr_res = 64'h4009_21FB_5444_2D18;
      for (int k = 0; k < 4; k++) begin
        bus_wr(1'b1, k, wa[k*16 +: 16], 3);
        bus_wr(1'b1, 4 + k, wb[k*16 +: 16], 3);
      end
      bus_wr(1'b1, 8, 16'h0002, 3);
      check("wide_core_a", core_a16, wa);
      check("wide_core_b", core_b16, wb);
      check("wide_busy", 64'(busy16), 64'(1'b1));
      check("wide_narrow_quiet", 64'(busy8), 64'(1'b0));
      @(negedge clk);
      core_done16 = 1'b1; core_result16 = wr_res; core_flags16 = 4'b0001;
      @(negedge clk);
      core_done16 = 1'b0;
      check("wide_cmd_end", 64'(cmd_end16), 64'(1'b1));
      rd_check(1'b1, "wide_res0", 10, 16'h2D18);
      rd_check(1'b1, "wide_res1", 11, 16'h5444);
      rd_check(1'b1, "wide_res2", 12, 16'h21FB);
      rd_check(1'b1, "wide_res3", 13, 16'h4009);
      rd_check(1'b1, "wide_status", 9, 16'h000A);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_bus_if.md
Name: fpu_bus_if

Overview:
- Parametrised host-bus front end for the FPU datapath. Successor to the fixed 8-bit/32-bit operand-and-command register interface.
- Generalises bus width and operand width. Adds a readable result window, a status register, a sticky write-while-busy error, and a formal start/done handshake to the arithmetic core.
- Sits between the CPU-side chip-select bus and the FPU core. Raises cmd_end as the interrupt source.

Parameters:
- DATA_W, 8: host data bus width in bits.
- OPERAND_W, 32: operand/result width. Must be a multiple of DATA_W. NB = OPERAND_W/DATA_W.
- ADDR_W, 6: host address width. Requires 3*NB+2 <= 2**ADDR_W.
- OPCODE_W, 4: width of the opcode field; the low OPCODE_W bits of a command write.
- FLAG_W, 4: core exception flag width. Requires FLAG_W <= DATA_W-3.

Ports:
- clk  in  1  system clock.
- arst  in  1  asynchronous, active-low reset.
- databus_in  in  DATA_W  host write data.
- databus_out  out  DATA_W  host read data.
- addr  in  ADDR_W  register address.
- cs  in  1  chip select, active-low.
- rd  in  1  read strobe, active-low.
- wr  in  1  write strobe, active-low.
- end_ack  in  1  active-high acknowledge of cmd_end.
- cmd_end  out  1  command complete / irq, level.
- busy  out  1  high while an operation is in flight.
- core_start  out  1  one-cycle launch pulse.
- core_op  out  OPCODE_W  latched opcode.
- core_a  out  OPERAND_W  operand A.
- core_b  out  OPERAND_W  operand B.
- core_done  in  1  one-cycle completion pulse.
- core_result  in  OPERAND_W  result, valid with core_done.
- core_flags  in  FLAG_W  exception flags, valid with core_done.

Behaviour:
- Address map. Lane k is bits [k*DATA_W +: DATA_W], little-endian.
  - A lanes: 0..NB-1.
  - B lanes: NB..2NB-1.
  - CMD: 2NB (write only).
  - STATUS: 2NB+1 (read only).
  - RESULT lanes: 2NB+2..3NB+1 (read only).
  - Defaults: A 0-3, B 4-7, CMD 8, STATUS 9, RESULT 10-13.
- STATUS bit layout: [0] busy, [1] cmd_end, [2] err, [3+:FLAG_W] last flags, rest 0.
- Strobe sampling:
  - cs, wr and rd each pass through a 2-flop synchroniser.
  - A write commits once, on the first clk edge after synced (cs=0 & wr=0) rises. Holding the strobe low does not repeat the write.
  - addr and databus_in must be stable while the strobe is low.
  - A read commit uses the same edge detection on (cs=0 & rd=0).
- databus_out:
  - Combinational mux of addr while raw cs=0 & rd=0; otherwise 0.
  - Unmapped or write-only addresses read 0.
  - Writes to unmapped or read-only addresses are ignored.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: cmd_end=1, busy=0.
- FSM transitions:
  - IDLE or DONE + CMD write commit: latch core_op, clear cmd_end, pulse core_start for exactly 1 cycle on the next cycle, go to RUN. busy rises with core_start.
  - RUN + core_done: latch core_result into RESULT and core_flags into STATUS, go to DONE. cmd_end and busy update on the following edge.
  - DONE + end_ack high on any sampled edge: clear cmd_end, go to IDLE.
  - core_done in IDLE or DONE is ignored; RESULT is unchanged.
- Write-while-busy:
  - In RUN, writes to A, B or CMD are dropped. Operands and opcode stay frozen; err is set.
  - err is sticky. It clears on a STATUS read commit. If a set and a clear coincide, the set wins.
- Simultaneous events:
  - core_done and end_ack in the same RUN cycle: done is taken and cmd_end is set. end_ack acts only in DONE.
  - CMD commit in the same cycle as end_ack in DONE: the command wins and goes to RUN.
- Operand registers are writable in IDLE and DONE without launching. Values persist across commands.
- Reset: arst low at any time, including mid-RUN, asynchronously clears:
  - FSM to IDLE;
  - cmd_end, busy, core_start, err, flags;
  - A, B, RESULT, opcode;
  - the synchroniser flops.
  - A core_done arriving after reset release is ignored.
- Latency: CMD strobe falling to core_start is 3-4 clk (synchroniser plus edge). core_done to cmd_end high is 1 clk.

Test Plan:
- Launch and read back (defaults): A=0x401ccccd, B=0x406a3d71, CMD=op_mul. Core model returns 0x410f78d5 after 10 cycles.
  - core_start pulses once and busy=1.
  - Then cmd_end=1 and busy=0.
  - RESULT bytes 10..13 read d5,78,0f,41.
- Acknowledge: pulse end_ack in DONE -> cmd_end=0 next edge, STATUS reads 0x00 (flags=0).
- Write while busy: write A lane 0 = 0xFF during RUN -> core_a unchanged, STATUS[2]=1. A second STATUS read returns err=0.
- Reset mid-operation: drop arst during RUN, then pulse core_done after release -> busy=0, cmd_end=0, RESULT=0, no irq.
- Long strobe and map edges: hold wr low 4 clk on CMD -> exactly one core_start. Read addr 14 or write addr 9 -> read 0, no state change.
- Wide configuration: DATA_W=16, OPERAND_W=64. Write A/B as 4 lanes each, CMD at 8. core_result 0x400921FB54442D18 with flags=4'b0001.
  - Lanes 10..13 read 2D18,5444,21FB,4009.
  - STATUS[3]=1.
